// File: rtl/alu_multicycle.sv
// RV32I integer ALU: single-cycle logic/arithmetic/compare ops, shifts iterated
// one bit per cycle through an accumulator while busy holds off new requests.
module alu_multicycle #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] register_data_1,
  input  logic [XLEN-1:0] register_data_2,
  output logic [XLEN-1:0] register_data_out,
  output logic            done,
  output logic            busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] acc;
  logic [4:0]      count;
  logic            shift_left;
  logic            shift_arith;

  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] shifted;
  logic [4:0]      shamt;
  logic            is_shift;

  assign shamt    = register_data_2[4:0];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Shift slots return zero here; those ops take the accumulator path instead.
  always_comb begin
    alu_result = '0;
    case (funct3)
      3'b000:  alu_result = funct7_5 ? (register_data_1 - register_data_2)
                                     : (register_data_1 + register_data_2);
      3'b010:  alu_result = {{(XLEN-1){1'b0}},
                             ($signed(register_data_1) < $signed(register_data_2))};
      3'b011:  alu_result = {{(XLEN-1){1'b0}}, (register_data_1 < register_data_2)};
      3'b100:  alu_result = register_data_1 ^ register_data_2;
      3'b110:  alu_result = register_data_1 | register_data_2;
      3'b111:  alu_result = register_data_1 & register_data_2;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    shifted = '0;
    if (shift_left) shifted = {acc[XLEN-2:0], 1'b0};
    else            shifted = {shift_arith & acc[XLEN-1], acc[XLEN-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      acc               <= '0;
      count             <= '0;
      shift_left        <= 1'b0;
      shift_arith       <= 1'b0;
      register_data_out <= '0;
      done              <= 1'b0;
      busy              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (!is_shift) begin
              register_data_out <= alu_result;
              done              <= 1'b1;
            end else if (shamt == 5'd0) begin
              register_data_out <= register_data_1;
              done              <= 1'b1;
            end else begin
              acc         <= register_data_1;
              count       <= shamt;
              shift_left  <= (funct3 == 3'b001);
              shift_arith <= (funct3 == 3'b101) && funct7_5;
              busy        <= 1'b1;
              state       <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc   <= shifted;
          count <= count - 5'd1;
          if (count == 5'd1) begin
            register_data_out <= shifted;
            done              <= 1'b1;
            busy              <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle: single-cycle ops, iterative
// shifts, busy back-pressure and reset during a shift.
module tb_alu_multicycle;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] register_data_1;
  logic [31:0] register_data_2;
  logic [31:0] register_data_out;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycles;

  alu_multicycle #(.XLEN(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .funct3            (funct3),
    .funct7_5          (funct7_5),
    .register_data_1   (register_data_1),
    .register_data_2   (register_data_2),
    .register_data_out (register_data_out),
    .done              (done),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one request for a single edge; outputs are then one edge past acceptance.
  task automatic applyStimulus(input logic [2:0] f3, input logic f7,
                               input logic [31:0] a, input logic [31:0] b);
    funct3          = f3;
    funct7_5        = f7;
    register_data_1 = a;
    register_data_2 = b;
    enable          = 1'b1;
    tick();
    enable          = 1'b0;
  endtask

  task automatic singleOp(input string tag, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expected);
    applyStimulus(f3, f7, a, b);
    checkOutput({tag, " done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, " result"}, register_data_out, expected);
    checkOutput({tag, " busy"}, {31'b0, busy}, 32'd0);
  endtask

  // Counts edges after acceptance until done, with busy required high meanwhile.
  task automatic runShift(input string tag, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input int k, input logic [31:0] expected);
    logic busy_ok;
    applyStimulus(f3, f7, a, b);
    cycles  = 0;
    busy_ok = 1'b1;
    while (!done && cycles < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cycles++;
    end
    checkOutput({tag, " busy while shifting"}, {31'b0, busy_ok}, 32'd1);
    checkOutput({tag, " done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, " latency"}, cycles, k);
    checkOutput({tag, " result"}, register_data_out, expected);
    checkOutput({tag, " busy after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic busy_ok;
    logic done_seen;

    reset           = 1'b1;
    enable          = 1'b0;
    funct3          = 3'b000;
    funct7_5        = 1'b0;
    register_data_1 = '0;
    register_data_2 = '0;
    tick();
    tick();
    checkOutput("reset out", register_data_out, 32'h0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("idle done", {31'b0, done}, 32'd0);

    // Back-to-back ADDs: done stays high across consecutive completions.
    funct3          = 3'b000;
    funct7_5        = 1'b0;
    register_data_1 = 32'd1;
    enable          = 1'b1;
    for (int b = 2; b <= 6; b++) begin
      register_data_2 = b;
      tick();
      checkOutput($sformatf("add 1+%0d done", b), {31'b0, done}, 32'd1);
      checkOutput($sformatf("add 1+%0d", b), register_data_out, 32'(b + 1));
    end
    enable = 1'b0;
    tick();
    checkOutput("hold done", {31'b0, done}, 32'd0);
    checkOutput("hold out", register_data_out, 32'd7);

    singleOp("sub",  3'b000, 1'b1, 32'd1,        32'd2,        32'hFFFF_FFFF);
    singleOp("add wrap", 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1,   32'h0000_0000);
    singleOp("slt",  3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd1);
    singleOp("sltu", 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0);
    singleOp("xor",  3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    singleOp("or",   3'b110, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    singleOp("and",  3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);

    // SLL by 5 with an ADD request held on the whole time it is busy.
    applyStimulus(3'b001, 1'b0, 32'd1, 32'd5);
    funct3          = 3'b000;
    funct7_5        = 1'b0;
    register_data_1 = 32'd100;
    register_data_2 = 32'd1;
    enable          = 1'b1;
    cycles          = 0;
    busy_ok         = 1'b1;
    while (!done && cycles < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cycles++;
    end
    enable = 1'b0;
    checkOutput("sll5 busy while shifting", {31'b0, busy_ok}, 32'd1);
    checkOutput("sll5 latency", cycles, 32'd5);
    checkOutput("sll5 result", register_data_out, 32'h0000_0020);
    checkOutput("sll5 busy after", {31'b0, busy}, 32'd0);
    tick();
    checkOutput("sll5 enable ignored done", {31'b0, done}, 32'd0);
    checkOutput("sll5 enable ignored out", register_data_out, 32'h0000_0020);

    runShift("sra31", 3'b101, 1'b1, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF);
    runShift("srl31", 3'b101, 1'b0, 32'h8000_0000, 32'd31, 31, 32'h0000_0001);
    runShift("sra4 neg", 3'b101, 1'b1, 32'hF000_00F0, 32'd4, 4, 32'hFF00_000F);
    singleOp("sll0", 3'b001, 1'b0, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678);

    // Reset ten edges into a 20-bit shift aborts it without a done pulse.
    applyStimulus(3'b001, 1'b0, 32'd1, 32'd20);
    done_seen = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (done === 1'b1) done_seen = 1'b1;
      tick();
    end
    checkOutput("abort busy before reset", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    if (done === 1'b1) done_seen = 1'b1;
    reset = 1'b0;
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort out", register_data_out, 32'h0);
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) done_seen = 1'b1;
      tick();
    end
    checkOutput("abort no done", {31'b0, done_seen}, 32'd0);
    singleOp("add after abort", 3'b000, 1'b0, 32'd1, 32'd2, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Multi-cycle RV32I integer ALU that responds to the operand/opcode stimulus driven by the ALU test benches and, later, the core's execute stage. Accepts one operation per `enable` pulse and returns a registered result with a `done` strobe. Logic/arithmetic/compare ops complete in one cycle. Shifts run iteratively, one bit per cycle, to avoid a barrel shifter. `busy` back-pressures the initiator during shifts.

## Interface
- `XLEN`, 32, operand/result width; shift amount width fixed at 5 bits (`register_data_2[4:0]`).
- `clock`  in  1  sole clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  request; sampled on rising edge; accepted only when `busy`=0.
- `funct3`  in  3  RV32I funct3 opcode select.
- `funct7_5`  in  1  alternate-op bit: SUB when funct3=000, SRA when funct3=101; ignored otherwise.
- `register_data_1`  in  XLEN  operand A (rs1).
- `register_data_2`  in  XLEN  operand B (rs2); bits [4:0] are the shift amount for shifts.
- `register_data_out`  out  XLEN  registered result; holds last result until the next completion.
- `done`  out  1  one-cycle strobe: `register_data_out` updated this cycle.
- `busy`  out  1  high while an iterative shift is in progress; new `enable` ignored.

## Operation
- funct3 map: 000 ADD/SUB, 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- Arithmetic is modulo 2^XLEN; carries/overflow discarded. SLT/SLTU result is 0 or 1, zero-extended.
- States: IDLE, SHIFT.
- IDLE, `enable`=1, non-shift op: result computed from the input operands; `register_data_out` and `done`=1 registered on the same edge; remain IDLE.
- IDLE, `enable`=1, shift op, shamt=0: `register_data_out`<=operand A, `done`=1; remain IDLE.
- IDLE, `enable`=1, shift op, shamt=k>0: latch operand A into accumulator, count<=k, latch direction and arithmetic flag, `busy`<=1; go to SHIFT.
- SHIFT, each edge: accumulator shifted by 1 (left fill 0; right fill 0 for SRL, sign bit for SRA), count decremented. On the edge where count goes 1->0: `register_data_out`<=shifted value, `done`<=1, `busy`<=0, go to IDLE.
- Inputs (operands, funct3, funct7_5) are not needed stable after the accepting edge.
- `enable` while `busy`=1: ignored, no queueing, no effect on the shift in progress.
- `done` is 0 on every edge that does not complete an operation; `register_data_out` never changes without `done`.

## Timing
- Reset values: `register_data_out`=0, `done`=0, `busy`=0, state IDLE, count=0.
- Reset mid-shift: operation aborted, no `done`, outputs to reset values on that edge.
- Non-shift / shamt=0 latency: accepted at edge N -> `done`=1 and result valid in cycle after edge N (1 cycle). Back-to-back acceptance every cycle; `done` stays high across consecutive completions.
- Shift, shamt=k>0: accepted at edge N; `busy`=1 after edges N..N+k-1; `done`=1 and result after edge N+k; `busy`=0 after edge N+k. Next `enable` accepted at edge N+k+1 at earliest (throughput k+1 cycles).
- Max shift latency 31 cycles.

## Test plan
- Reset, then `enable`=1, funct3=000, A=1, B=2 -> `done`=1 one cycle later, `register_data_out`=0x00000003; then A=1, B=3..6 on consecutive cycles -> outputs 4,5,6,7 each with `done`=1.
- SUB: funct7_5=1, funct3=000, A=1, B=2 -> 0xFFFFFFFF; ADD A=0xFFFFFFFF, B=1 -> 0x00000000 (wrap).
- Compare: A=0xFFFFFFFF, B=1: SLT -> 1, SLTU -> 0; XOR/OR/AND with A=0xF0F0F0F0, B=0x0FF00FF0 -> 0xFF00FF00 / 0xFFF0FFF0 / 0x00F000F0.
- SLL A=1, B=5 -> `busy` high 5 cycles, `done` after 5 edges, result 0x00000020; `enable` with ADD asserted while busy -> ignored, result unchanged.
- SRA A=0x80000000, B=31 -> 0xFFFFFFFF after 31 cycles; SRL same operands -> 0x00000001; SLL shamt=0, A=0x12345678 -> 0x12345678 in 1 cycle, `busy` never high.
- SLL A=1, B=20, assert `reset` after 10 cycles -> `busy`=0, `done` never pulses, `register_data_out`=0; next ADD 1+2 -> 3 normally.
